// File: rtl/y_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and counter sizing.
package y_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  // The multiply counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/y_adder_w.sv
// Plain ripple-carry adder shared by the ALU's add/sub/compare path and the multiplier.
module y_adder_w #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] z,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  logic carry;

  // Ripple the carry from bit 0 upward, producing each sum bit on the way.
  always_comb begin
    carry = cin;
    z     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      z[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/y_alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides. Logic ops, add/sub and signed
// set-less-than finish in one cycle; MUL iterates a shift-add loop for WIDTH cycles.
module y_alu_mc
  import y_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ex,
  output logic             zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, next_state;
  logic [WIDTH-1:0]   z_q;
  logic               ex_q;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     acc_upper;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   add_a, add_b, sum;
  logic               add_cin, cout;
  logic               is_sub, ovf;
  logic [WIDTH-1:0]   alu_z;
  logic               alu_ex;

  y_adder_w #(.WIDTH(WIDTH)) u_adder (
    .z    (sum),
    .cout (cout),
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin)
  );

  // Share the adder: operands come from the ports while idle, from the multiply datapath while iterating.
  always_comb begin
    is_sub  = (op == OP_SUB) || (op == OP_SLT);
    add_a   = a;
    add_b   = is_sub ? ~b : b;
    add_cin = is_sub;
    if (state == MUL) begin
      add_a   = acc[2*WIDTH-1:WIDTH];
      add_b   = mcand;
      add_cin = 1'b0;
    end
  end

  // Single-cycle results; overflow means equal operand signs but a different sum sign.
  always_comb begin
    ovf    = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);
    alu_z  = '0;
    alu_ex = 1'b0;
    case (op)
      OP_AND: alu_z = a & b;
      OP_OR:  alu_z = a | b;
      OP_ADD: begin
        alu_z  = sum;
        alu_ex = ovf;
      end
      OP_SUB: begin
        alu_z  = sum;
        alu_ex = ovf;
      end
      OP_SLT: alu_z = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_MUL: alu_z = '0;
      default: begin
        alu_z  = '0;
        alu_ex = 1'b1;
      end
    endcase
  end

  // One shift-add step: optionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    acc_upper = mplier[0] ? {cout, sum} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    acc_next  = (2*WIDTH)'({acc_upper, acc[WIDTH-1:0]} >> 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = (op == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (cnt == CW'(1)) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: capture on accept, iterate the multiply, hold the result while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_q    <= '0;
      ex_q   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
            end else begin
              z_q  <= alu_z;
              ex_q <= alu_ex;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            z_q  <= acc_next[WIDTH-1:0];
            ex_q <= |acc_next[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign z    = z_q;
  assign ex   = ex_q;
  assign zero = (z_q == '0);

endmodule

// File: doc/y_alu_mc.md
# y_alu_mc

Parametrised multi-cycle ALU, successor to the 32-bit combinational ALU. It is generalised to WIDTH bits and implements the missing set-less-than op. It adds a shift-add multiply, overflow/illegal-op reporting and a valid/ready handshake on both sides. It sits between the register-read stage and writeback, and stalls upstream while a multiply iterates.

## Interface
- WIDTH, 32, operand/result width in bits (>= 4)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op present
- in_ready  output  1  block can accept a command this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation code
- out_valid  output  1  z/ex/zero hold a result
- out_ready  input  1  consumer takes result this cycle
- z  output  WIDTH  result
- ex  output  1  exception flag
- zero  output  1  z == 0

## Operation
- Op codes:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT: signed; z = {0…, a<b}
  - 011 MUL: unsigned, low WIDTH bits of product
  - 100, 101 illegal
- ex:
  - ADD/SUB: signed overflow, i.e. operand signs agree (b inverted for SUB) and the result sign differs.
  - MUL: any nonzero bit in the upper WIDTH bits of the full product.
  - AND/OR/SLT: 0.
  - Illegal op: z=0, ex=1.
- SUB and SLT use a + ~b + 1 through the shared adder. SLT = sum_msb XOR signed_overflow.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On accept (in_valid & in_ready), a non-MUL op is computed and registered, then go to DONE. MUL latches the multiplicand, multiplier and a 2·WIDTH accumulator of 0, loads the counter with WIDTH, and goes to MUL.
  - MUL: each cycle, if multiplier[0] is set, add the multiplicand into the accumulator's upper half. Then shift the accumulator and multiplier right by 1 and decrement the counter. When the counter reaches 0, register z/ex and go to DONE.
  - DONE: out_valid=1 and outputs held stable. If out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Inputs are sampled only on the accept edge; later input changes have no effect.
- zero is derived from the registered z and is valid whenever out_valid=1.

## Timing
- Reset (synchronous, edge with reset=1):
  - Outputs: state=IDLE, in_ready=1, out_valid=0, z=0, ex=0, zero=1, counter=0.
  - Reset wins over every other event, including mid-MUL and DONE with out_ready=1. The pending result is discarded.
- Single-cycle op: accepted at edge N → out_valid=1 from cycle N+1.
- MUL: accepted at edge N → out_valid=1 from cycle N+WIDTH+1. in_ready=0 for cycles N+1 … until the DONE handoff.
- Handoff: edge with out_valid & out_ready → out_valid=0 and in_ready=1 in the next cycle. New commands are not accepted in the same cycle as a DONE handoff.
  - Peak throughput is 1 result per 2 cycles for single-cycle ops and 1 per WIDTH+2 cycles for MUL.
- Backpressure: out_ready=0 holds DONE indefinitely with z/ex/zero unchanged.
- Widths:
  - All add/sub arithmetic wraps modulo 2^WIDTH.
  - Adder carry-out is unused except internally for MUL accumulation, which uses a WIDTH+1-bit sum into the accumulator's upper half.
  - MUL by 0 still takes WIDTH cycles; there is no early exit.

## Structure
- Package y_alu_pkg:
  - op code localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL
  - state enum (IDLE, MUL, DONE)
  - counter width as $clog2(WIDTH+1)
- Sub-module y_adder_w #(WIDTH): ripple adder (z, cout, a, b, cin). One instance is shared by ADD/SUB/SLT in IDLE and by MUL accumulation in MUL, with operands muxed by state.
- Everything else stays inline: the FSM, the logic ops, and the result/ex registers.

## Test plan
- Reset mid-MUL: accept MUL at WIDTH=32, assert reset 5 cycles later → next cycle in_ready=1, out_valid=0, z=0, zero=1; no result appears.
- ADD/SUB overflow:
  - ADD a=0x7FFFFFFF, b=1 → z=0x80000000, ex=1, out_valid at N+1.
  - SUB a=5, b=5 → z=0, zero=1, ex=0.
- SLT signed: a=0xFFFFFFFF (-1), b=1 → z=1. Swapped operands → z=0. Both cases ex=0.
- MUL latency/overflow:
  - a=12345, b=678 → z=8369910, ex=0, out_valid exactly at N+33.
  - a=0x10000, b=0x10000 → z=0, ex=1.
- Backpressure and handshake: hold out_ready=0 for 10 cycles after AND a=0xF0F0, b=0xFF00 → z=0x0000F000 stable, in_ready=0, and new in_valid is ignored. Release → out_valid=0 and in_ready=1 in the next cycle.
- Illegal op and WIDTH=8 build:
  - op=100 → z=0, ex=1.
  - WIDTH=8 MUL a=16, b=16 → z=0, ex=1, out_valid at N+9.
